// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the digit-serial BCD adder
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef logic [3:0] digit_t;
   localparam digit_t BCD_MAX  = 4'd9;
   localparam digit_t BCD_CORR = 4'd6;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder with decimal carry
module bcd_digit_add
   import bcd_pkg::*;
(
   input  digit_t a_d,
   input  digit_t b_d,
   input  logic   c_in,
   output digit_t s_d,
   output logic   c_out
);
   logic [4:0] t;
   logic [4:0] t_corr;
   // binary sum, then +6 correction whenever it exceeds one decimal digit
   always_comb begin
      t      = {1'b0, a_d} + {1'b0, b_d} + {4'd0, c_in};
      t_corr = t + {1'b0, BCD_CORR};
      c_out  = t > {1'b0, BCD_MAX};
      s_d    = c_out ? t_corr[3:0] : t[3:0];
   end
endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: sequences one BCD digit adder across DIGITS digits, LSD first.
// Optional invalid-digit detection on err enabled by defining BCD_ERR_CHECK_EN.
module bcd_serial_adder_ctrl
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                cin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] sum,
   output logic                cout,
   output logic                err
);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);
   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic                carry_q, carry_d, cout_q, cout_d;
   digit_t              a_dig, b_dig, s_dig;
   logic                c_dig;
   assign a_dig = digit_t'(a_q >> {idx_q, 2'b00});
   assign b_dig = digit_t'(b_q >> {idx_q, 2'b00});
   bcd_digit_add u_add (
      .a_d  (a_dig),
      .b_d  (b_dig),
      .c_in (carry_q),
      .s_d  (s_dig),
      .c_out(c_dig)
   );
`ifdef BCD_ERR_CHECK_EN
   logic err_q, err_d;
   // sticky flag: any captured digit above 9 seen during RUN
   always_comb begin
      err_d = err_q;
      if (state_q == IDLE && start) err_d = 1'b0;
      else if (state_q == RUN && (a_dig > BCD_MAX || b_dig > BCD_MAX)) err_d = 1'b1;
   end
   // error flag register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_q <= 1'b0;
      else err_q <= err_d;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif
   // next-state and datapath updates: capture in IDLE, one digit per RUN cycle
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      unique case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            idx_d   = '0;
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            sum_d   = '0;
            cout_d  = 1'b0;
         end
         RUN: begin
            for (int i = 0; i < DIGITS; i++)
               if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = s_dig;
            carry_d = c_dig;
            idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            if (idx_q == LAST) begin
               state_d = DONE;
               cout_d  = c_dig;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state, index, operand and result registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl: directed self-checking bench for the serial BCD adder
module tb_bcd_serial_adder_ctrl;
   localparam int DIGITS = 4;
   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [4*DIGITS-1:0] a = '0, b = '0;
   logic                cin = 1'b0;
   logic                busy, done, cout, err;
   logic [4*DIGITS-1:0] sum;
   int checks = 0;
   int errors = 0;
`ifdef BCD_ERR_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive one start pulse at a negedge, then wait (bounded) for done; n = cycles to done
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, output int n);
      a = ta; b = tb_; cin = tc; start = 1'b1;
      n = 0;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic op_check(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                           input logic tc, input logic [15:0] es, input logic ec, input logic ee);
      int n;
      run_op(ta, tb_, tc, n);
      chk({tag, "_lat"}, n, DIGITS + 1);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_err"}, err, ee);
      @(negedge clk);
      chk({tag, "_donepulse"}, {busy, done}, 0);
   endtask

   initial begin
      int n, dones;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // basic operations and carry ripple
      op_check("t1", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
      op_check("t2a", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      op_check("t2b", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
      op_check("t3a", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
      op_check("t3b", 16'h0708, 16'h0508, 1'b0, 16'h1216, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      chk("t3_hold_sum", sum, 16'h1216);
      chk("t3_hold_cout", cout, 0);
      // start pulses and operand changes while busy are ignored
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t4_busy", busy, 1);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         a = 16'h5555; b = 16'h4444; cin = 1'b1;
         start = (i == 1 || i == 3) ? 1'b1 : 1'b0;
         if (done) begin
            dones++;
            start = 1'b1;
            chk("t4_sum", sum, 16'h3333);
            chk("t4_cout", cout, 0);
         end
         @(negedge clk);
         start = 1'b0;
      end
      chk("t4_ndone", dones, 1);
      // back-to-back with start held high: one op every DIGITS+2 cycles
      a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
      n = 0;
      while (!done && n < 50) begin @(negedge clk); n++; end
      n = 0;
      @(negedge clk);
      while (!done && n < 50) begin @(negedge clk); n++; end
      chk("b2b_period", n + 1, DIGITS + 2);
      chk("b2b_sum", sum, 16'h0003);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      // asynchronous reset while idx=2 aborts with no done
      a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_outs", {busy, done, cout, err, sum}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      chk("t5_no_done", dones, 0);
      op_check("t5_after", 16'h4321, 16'h1234, 1'b0, 16'h5555, 1'b0, 1'b0);
      // invalid digit: arithmetic rule still applied, err depends on build
      op_check("t6a", 16'h00A1, 16'h0001, 1'b0, 16'h0102, 1'b0, ERR_EXP);
      op_check("t6b", 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
